cut_scan_param: RTL and testbench
=================================

Name: cut_scan_param

Overview:
- Parametrised next-generation circuit-under-test for the per-scan BIST flow.
- Functional mode: a read-sequencer FSM. It is armed by dv, then steps an address (up or down, selected by l_in), emits periodic latch-clock pulses, and ends in a timed freeze window.
- Scan mode (s=1): every internal flop is stitched into CHAINS balanced scan chains, driven by test_in and observed on test_out, so the BIST controller can load and unload state.

Parameters:
- CHAINS, 2, number of scan chains (≥1); width of test_in and test_out.
- ADDR_W, 5, width of read_a.
- DEPTH, 32, number of addresses swept; 2 ≤ DEPTH ≤ 2^ADDR_W.
- LCLK_DIV, 4, lclk period in READ cycles (≥2).
- FZ_CYCLES, 3, length of the fz_L low window in cycles (≥1).

Ports:
- clock, input, 1, single system clock; all flops rising-edge.
- reset, input, 1, synchronous active-high reset; priority over s and all functional logic.
- s, input, 1, scan enable; 1 = shift, 0 = functional.
- dv, input, 1, data valid; starts a sweep and must stay high to sustain it.
- l_in, input, 1, direction select sampled in ARM; 0 = up, 1 = down.
- test_in, input, CHAINS, scan-in, one bit per chain.
- fz_L, output, 1, freeze, active low.
- lclk, output, 1, latch-clock pulse, one cycle wide.
- read_a, output, ADDR_W, current read address.
- busy, output, 1, high whenever state ≠ IDLE.
- test_out, output, CHAINS, scan-out, one bit per chain.

Behaviour:
- Flops:
  - state: 2 bits; IDLE=0, ARM=1, READ=2, FREEZE=3.
  - dir: 1 bit.
  - read_a: ADDR_W bits.
  - div_cnt: max(1, clog2(LCLK_DIV)) bits.
  - fz_cnt: max(1, clog2(FZ_CYCLES)) bits.
- Reset: all flops go to 0, including pad flops. Resulting outputs: fz_L=1, lclk=0, read_a=0, busy=0, test_out=0.
- Functional mode (s=0), transitions on clock edge:
  - IDLE: on dv=1, go to ARM.
  - ARM: always lasts one cycle.
    - dir <= l_in.
    - read_a <= 0 if l_in=0, else DEPTH-1.
    - div_cnt <= 0; next state READ.
  - READ, early exit: if dv=0, go to FREEZE and hold read_a. This has priority over stepping.
  - READ, terminal exit: otherwise, if read_a is at the terminal value, go to FREEZE and hold read_a. Terminal is DEPTH-1 when dir=0 and 0 when dir=1.
  - READ, stepping: otherwise read_a increments (dir=0) or decrements (dir=1).
  - READ, divider: div_cnt wraps modulo LCLK_DIV every READ cycle.
  - READ entry: fz_cnt <= 0.
  - FREEZE: fz_cnt increments each cycle. When fz_cnt = FZ_CYCLES-1, go to IDLE and set read_a <= 0. dv is ignored in FREEZE.
- Sweep timing: a full sweep with dv held is 1 cycle IDLE→ARM, 1 ARM cycle, then DEPTH READ cycles, then FZ_CYCLES FREEZE cycles.
- Combinational outputs, taken from flops only:
  - fz_L = !(state==FREEZE).
  - lclk = (state==READ) && (div_cnt==LCLK_DIV-1) && !s.
  - busy = (state≠IDLE).
- Scan vector SV, LSB first: {state, dir, read_a, div_cnt, fz_cnt, pad}.
  - W = total width of the real flops; L = ceil(W/CHAINS).
  - Zero-filled pad flops extend SV to CHAINS*L bits.
  - Chain k owns SV[k*L +: L].
- Scan mode (s=1): each clock, every chain shifts toward its MSB.
  - SV[k*L] <= test_in[k].
  - test_out[k] = SV[k*L+L-1] at all times, in both modes.
  - No functional update occurs while s=1.
  - lclk is forced to 0; fz_L, read_a and busy reflect the shifted flop contents.
- Scan-loaded values:
  - On return to s=0, the FSM continues from whatever was loaded.
  - read_a beyond DEPTH-1 in READ steps normally; an up-count wraps modulo 2^ADDR_W.
  - Out-of-range div_cnt or fz_cnt counts on modulo its width until it matches.
- Reset mid-sweep or mid-shift: all flops return to 0 on the next edge.

Test Plan:
- Reset, then dv=1 held, l_in=0 (defaults) -> ARM one cycle later. read_a steps 0..31 over 32 READ cycles. lclk pulses when read_a=3,7,...,31 (8 pulses). fz_L low for exactly 3 cycles. busy drops and read_a returns to 0.
- dv=1, l_in=1 -> read_a runs 31 down to 0, then FREEZE; 8 lclk pulses.
- dv dropped when read_a=10 during an up sweep -> FREEZE on the next edge with read_a held at 10; fz_L low 3 cycles; no further lclk.
- Reset, s=1, test_in=2'b11 for 6 cycles (W=12, L=6) -> test_out=2'b11. Then s=0 -> state=FREEZE(3), fz_L=0, busy=1. It returns to IDLE once fz_cnt reaches 2 (fz_cnt loaded as 3 wraps 3→0→1→2).
- Scan round-trip: shift a 12-bit pattern in, shift 6 more cycles with test_in=0 -> the same pattern appears on test_out in order.
- Assert reset while in READ with s=0, and again mid-shift with s=1 -> next edge gives read_a=0, fz_L=1, lclk=0, busy=0, test_out=0.

Source files
------------

// File: rtl/cut_scan_param.sv
// cut_scan_param: read-sequencer FSM whose flops double as CHAINS balanced scan chains.
// All state lives in one scan vector; the named fields below are slices of it.
module cut_scan_param #(
    parameter int CHAINS    = 2,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int LCLK_DIV  = 4,
    parameter int FZ_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s,
    input  logic              dv,
    input  logic              l_in,
    input  logic [CHAINS-1:0] test_in,
    output logic              fz_L,
    output logic              lclk,
    output logic [ADDR_W-1:0] read_a,
    output logic              busy,
    output logic [CHAINS-1:0] test_out
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARM    = 2'd1;
    localparam logic [1:0] READ   = 2'd2;
    localparam logic [1:0] FREEZE = 2'd3;
    localparam int DW = ($clog2(LCLK_DIV) > 1) ? $clog2(LCLK_DIV) : 1;
    localparam int FW = ($clog2(FZ_CYCLES) > 1) ? $clog2(FZ_CYCLES) : 1;
    localparam int W  = 3 + ADDR_W + DW + FW;
    localparam int L  = (W + CHAINS - 1) / CHAINS;
    localparam int N  = CHAINS * L;

    logic [N-1:0]      sv_q, sv_d, shift_d, func_d;
    logic [1:0]        state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     div_q, div_d;
    logic [FW-1:0]     fz_q, fz_d;
    logic              stop;

    assign state_q = sv_q[1:0];
    assign dir_q   = sv_q[2];
    assign addr_q  = sv_q[3 +: ADDR_W];
    assign div_q   = sv_q[3+ADDR_W +: DW];
    assign fz_q    = sv_q[3+ADDR_W+DW +: FW];

    // Dropping dv wins over stepping; either way the address is held into FREEZE.
    assign stop = !dv || (dir_q ? (addr_q == '0) : (addr_q == ADDR_W'(DEPTH - 1)));

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        div_d   = div_q;
        fz_d    = fz_q;
        case (state_q)
            IDLE: state_d = dv ? ARM : IDLE;
            ARM: begin
                dir_d   = l_in;
                addr_d  = l_in ? ADDR_W'(DEPTH - 1) : '0;
                div_d   = '0;
                fz_d    = '0;
                state_d = READ;
            end
            READ: begin
                div_d   = (div_q == DW'(LCLK_DIV - 1)) ? '0 : div_q + DW'(1);
                state_d = stop ? FREEZE : READ;
                addr_d  = stop ? addr_q : dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            end
            default: begin
                fz_d    = fz_q + FW'(1);
                state_d = (fz_q == FW'(FZ_CYCLES - 1)) ? IDLE : FREEZE;
                addr_d  = (fz_q == FW'(FZ_CYCLES - 1)) ? '0 : addr_q;
            end
        endcase
    end

    assign func_d = N'({fz_d, div_d, addr_d, dir_d, state_d});

    // Whole-vector shift, then each chain head is overwritten with its scan input.
    always_comb begin
        shift_d = {sv_q[N-2:0], 1'b0};
        for (int k = 0; k < CHAINS; k++) shift_d[k*L] = test_in[k];
    end

    assign sv_d = s ? shift_d : func_d;

    always_ff @(posedge clock) begin
        sv_q <= reset ? '0 : sv_d;
    end

    for (genvar g = 0; g < CHAINS; g++) begin : g_tap
        assign test_out[g] = sv_q[g*L+L-1];
    end

    assign fz_L   = state_q != FREEZE;
    assign lclk   = (state_q == READ) && (div_q == DW'(LCLK_DIV - 1)) && !s;
    assign read_a = addr_q;
    assign busy   = state_q != IDLE;
endmodule

// File: tb/tb_cut_scan_param.sv
// tb_cut_scan_param: vector table driven through a scoreboard against cut_scan_param defaults.
module tb_cut_scan_param;
    logic       clock, reset, s, dv, l_in;
    logic [1:0] test_in, test_out;
    logic       fz_L, lclk, busy;
    logic [4:0] read_a;

    cut_scan_param dut (
        .clock(clock), .reset(reset), .s(s), .dv(dv), .l_in(l_in), .test_in(test_in),
        .fz_L(fz_L), .lclk(lclk), .read_a(read_a), .busy(busy), .test_out(test_out)
    );

    typedef struct {
        logic [63:0] nm;
        int          id;
        logic        r, sc, d, l;
        logic [1:0]  ti;
        logic [9:0]  exp, mask;
    } vec_t;

    localparam logic [9:0] MF = 10'h3FF;
    localparam logic [9:0] MN = 10'h3FC;
    localparam logic [9:0] MS = 10'h103;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   next_id = 0;

    initial clock = 0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [63:0] nm, input logic r, sc, d, l, input logic [1:0] ti,
                                input logic fzl, lc, input logic [4:0] a, input logic bz,
                                input logic [1:0] to, input logic [9:0] mask);
        vec_t v;
        v.nm = nm; v.id = 0; v.r = r; v.sc = sc; v.d = d; v.l = l; v.ti = ti;
        v.exp = {fzl, lc, a, bz, to};
        v.mask = mask;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        v.id = next_id;
        next_id++;
        reset = v.r; s = v.sc; dv = v.d; l_in = v.l; test_in = v.ti;
        sb.push_back(v);
        @(posedge clock);
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    always @(posedge clock) begin
        vec_t v;
        logic [9:0] act;
        #1;
        if (sb.size() > 0) begin
            v = sb.pop_front();
            act = {fz_L, lclk, read_a, busy, test_out};
            if (v.mask != 0) begin
                checks++;
                if ((act & v.mask) === (v.exp & v.mask)) passed++;
                else $display("FAIL %0s #%0d: got {fzL,lclk,a,busy,to}=%b required %b (mask %b)",
                              v.nm, v.id, act, v.exp, v.mask);
            end
        end
    end

    initial begin
        logic [5:0]  p0, p1;
        logic [11:0] ld;
        reset = 1; s = 0; dv = 0; l_in = 0; test_in = 0;
        p0 = 6'b101101;
        p1 = 6'b010011;

        vecs.push_back(mk("rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, MF));
        // full up sweep; dv kept high through FREEZE to show it is ignored there
        vecs.push_back(mk("up_arm", 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, MN));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk("up_rd", 0, 0, 1, 0, 0, 1, (i % 4 == 3), 5'(i), 1, 0, MN));
        for (int f = 0; f < 3; f++)
            vecs.push_back(mk("up_fz", 0, 0, 1, 0, 0, 0, 0, 31, 1, 0, MN));
        vecs.push_back(mk("up_idle", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, MN));
        vecs.push_back(mk("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MN));
        // down sweep; l_in high only in the ARM cycle
        vecs.push_back(mk("dn_arm", 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, MN));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk("dn_rd", 0, 0, 1, (i == 0), 0, 1, (i % 4 == 3), 5'(31 - i), 1, 0, MN));
        for (int f = 0; f < 3; f++)
            vecs.push_back(mk("dn_fz", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MN));
        vecs.push_back(mk("dn_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MN));
        // dv dropped at read_a=10
        vecs.push_back(mk("dr_arm", 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, MN));
        for (int i = 0; i <= 10; i++)
            vecs.push_back(mk("dr_rd", 0, 0, 1, 0, 0, 1, (i % 4 == 3), 5'(i), 1, 0, MN));
        for (int f = 0; f < 3; f++)
            vecs.push_back(mk("dr_fz", 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, MN));
        vecs.push_back(mk("dr_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MN));
        // reset in the middle of READ
        vecs.push_back(mk("rr_arm", 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, MN));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("rr_rd", 0, 0, 1, 0, 0, 1, (i % 4 == 3), 5'(i), 1, 0, MN));
        vecs.push_back(mk("rr_rst", 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, MF));
        vecs.push_back(mk("rr_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MF));
        // scan in all ones, then run the loaded FREEZE out
        for (int k = 1; k <= 6; k++)
            vecs.push_back(mk("sc1", 0, 1, 0, 0, 2'b11, !(k >= 2), 0,
                              {k >= 2, k >= 1, k >= 6, k >= 5, k >= 4}, 1, {2{k >= 6}}, MF));
        for (int f = 0; f < 3; f++)
            vecs.push_back(mk("sc1_fz", 0, 0, 0, 0, 0, 0, 0, 31, 1, 0, MN));
        vecs.push_back(mk("sc1_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MN));
        // scan round-trip: first bit shifted in is first out
        vecs.push_back(mk("rt_rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, MF));
        for (int j = 0; j < 12; j++)
            vecs.push_back(mk("rt", 0, 1, 0, 0, (j < 6) ? {p1[j % 6], p0[j % 6]} : 2'b00, 0, 0, 0, 0,
                              (j >= 5 && j <= 10) ? {p1[(j + 1) % 6], p0[(j + 1) % 6]} : 2'b00, MS));
        // reset in the middle of a shift
        for (int j = 0; j < 3; j++)
            vecs.push_back(mk("rs_sh", 0, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0, MS));
        vecs.push_back(mk("rs_rst", 1, 1, 0, 0, 2'b11, 1, 0, 0, 0, 0, MF));
        vecs.push_back(mk("rs_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MF));

        @(posedge clock);
        #2;
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        drain();

        // scan-load READ, read_a=5, div_cnt=3: lclk must stay low until s drops
        ld = 12'h32A;
        for (int j = 0; j < 6; j++)
            drive(mk("ld", 0, 1, 0, 0, {ld[11 - j], ld[5 - j]}, 1, 0, 5, 1, 2'b01, (j == 5) ? MF : 10'h000));
        drain();
        s = 0; dv = 1;
        #1;
        checks++;
        if (lclk === 1'b1) passed++;
        else $display("FAIL ld_lclk: got lclk=%b required 1", lclk);
        drive(mk("ld_rd", 0, 0, 1, 0, 0, 1, 0, 6, 1, 0, MN));
        drive(mk("ld_rd", 0, 0, 1, 0, 0, 1, 0, 7, 1, 0, MN));
        drive(mk("ld_rd", 0, 0, 1, 0, 0, 1, 0, 8, 1, 0, MN));
        drive(mk("ld_rd", 0, 0, 1, 0, 0, 1, 1, 9, 1, 0, MN));
        drive(mk("ld_fz", 0, 0, 0, 0, 0, 0, 0, 9, 1, 0, MN));
        drive(mk("ld_rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, MF));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
